traffic_phase_arbiter: RTL
==========================

// Module: traffic_phase_arbiter
// PURPOSE
//   Demand-driven scheduler for a 4-way junction (N,S,E,W). Samples per-approach vehicle sensors and
//   grants green to one approach at a time, round-robin. Enforces min/max green, yellow and all-red
//   clearance. Drives the per-approach light buses: 3'b001 green, 3'b010 yellow, 3'b100 red.
// PARAMETERS
//   MIN_GREEN    4   minimum green cycles before a pre-emptive hand-off (>=1)
//   MAX_GREEN    16  green cycles after which a waiting approach forces hand-off (>MIN_GREEN)
//   YELLOW_TIME  3   yellow duration in cycles (>=1)
//   ALLRED_TIME  1   all-red clearance in cycles (>=1)
//   CNT_W        5   phase timer width; must hold MAX_GREEN-1
// PORTS
//   clk       in   1  clock, all logic on posedge
//   rst       in   1  reset, synchronous, active-low
//   req       in   4  level vehicle sensors, bit0=N bit1=S bit2=E bit3=W
//   n_lights  out  3  north light bus (registered)
//   s_lights  out  3  south light bus (registered)
//   e_lights  out  3  east light bus (registered)
//   w_lights  out  3  west light bus (registered)
//   grant     out  4  one-hot approach currently green or yellow; 0 in ALL_RED/IDLE
// BEHAVIOUR
//   Reset (rst=0 at posedge): state IDLE, timer 0, all lights 3'b100, grant 0, rr pointer=W (N first).
//   States: IDLE (all red) -> GREEN -> YELLOW -> ALL_RED -> GREEN|IDLE. timer clears on every state change.
//   Arbitration: winner = first set req bit scanning from (last served + 1) mod 4; pointer updates on grant.
//   IDLE: req==0 -> stay. Any req at cycle t -> GREEN for winner, lights visible at t+1 (1-cycle latency).
//   GREEN: timer increments, saturates at MAX_GREEN-1. others = req & ~grant.
//     timer>=MIN_GREEN-1 and others!=0 -> YELLOW next cycle. Green therefore lasts MIN_GREEN..MAX_GREEN cycles.
//     others==0 -> rest in green indefinitely, even if own req drops.
//   YELLOW: exactly YELLOW_TIME cycles, then ALL_RED. Requests ignored.
//   ALL_RED: exactly ALLRED_TIME cycles, grant 0, all 3'b100. Last cycle: arbitrate on current req
//     (including just-served approach, which has lowest priority); req==0 -> IDLE.
//   Exactly one approach non-red at any time; never green->red without YELLOW.
//   Simultaneous requests resolved solely by rr pointer. Reset mid-phase aborts at once to IDLE/all-red.
// CONFIGURATION
//   EMERGENCY_PREEMPT_EN defined: adds ports emg_req in 1 (level), emg_dir in 2 (0=N..3=W).
//     emg_req in GREEN for a different approach -> YELLOW next cycle, min green ignored.
//     emg_req in IDLE or last ALL_RED cycle -> emg_dir wins regardless of req/pointer; pointer set to emg_dir.
//     emg_dir green while emg_req=1 -> held green, max green ignored. YELLOW/ALL_RED never shortened.
//   Undefined: ports absent, pure round-robin as above.
// STRUCTURE
//   traffic_pkg: LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN 3-bit constants, DIR_N..DIR_W indices,
//     phase_t state enum (IDLE, GREEN, YELLOW, ALL_RED).
//   Sub-module rr_arbiter_4: combinational req[3:0] + ptr[1:0] -> one-hot gnt[3:0], valid.
//   Top holds FSM, phase timer, rr pointer, registered light decode.
// TESTING
//   Reset, req=0 for 20 cycles -> IDLE, all lights 3'b100, grant=0.
//   From IDLE req=4'b0001 held -> n_lights=001 next cycle; stays green 30 cycles (no other req).
//   N green, S req at green cycle 1 -> N green 4 cycles, yellow 3, all-red 1, then s_lights=001.
//   N green from cycle 0, E req from cycle 10 (after min) -> hand-off at cycle 11; req=4'b1111 ->
//     grants cycle N,S,E,W,N; max-green 16 caps each when others wait.
//   rst low during YELLOW -> next cycle all 3'b100, grant 0; release with req=4'b0100 -> E green.
//   EMERGENCY_PREEMPT_EN: N green cycle 1, emg_req=1 emg_dir=W -> yellow next cycle, W green after
//     all-red; W held 40 cycles despite S req; emg_req=0 -> normal hand-off to S.

Source files
------------

// File: rtl/traffic_phase_arbiter_pkg.sv
// traffic_pkg: light encodings, approach indices and phase states shared by traffic_phase_arbiter
package traffic_pkg;
  localparam logic [2:0] LIGHT_GREEN = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;
  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALL_RED} phase_t;
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/traffic_phase_arbiter_if.sv
// traffic_phase_arbiter_if: sensor and light buses; EMERGENCY_PREEMPT_EN adds emg_req/emg_dir
interface traffic_phase_arbiter_if;
  logic [3:0] req;
  logic [2:0] n_lights;
  logic [2:0] s_lights;
  logic [2:0] e_lights;
  logic [2:0] w_lights;
  logic [3:0] grant;
`ifdef EMERGENCY_PREEMPT_EN
  logic emg_req;
  logic [1:0] emg_dir;
  modport master (output req, emg_req, emg_dir, input n_lights, s_lights, e_lights, w_lights, grant);
  modport slave (input req, emg_req, emg_dir, output n_lights, s_lights, e_lights, w_lights, grant);
`else
  modport master (output req, input n_lights, s_lights, e_lights, w_lights, grant);
  modport slave (input req, output n_lights, s_lights, e_lights, w_lights, grant);
`endif
endinterface

// File: rtl/traffic_phase_arbiter_rr_arbiter_4.sv
// rr_arbiter_4: one-hot grant to the first requester after ptr in circular order N,S,E,W
module rr_arbiter_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       valid
);
  always_comb begin
    gnt = '0;
    for (int i = 4; i >= 1; i--)
      gnt = req[ptr + 2'(i)] ? 4'b1 << (ptr + 2'(i)) : gnt;
    valid = |req;
  end
endmodule

// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter: round-robin 4-way junction phase scheduler; EMERGENCY_PREEMPT_EN adds pre-emption
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst,
  traffic_phase_arbiter_if.slave bus
);
  phase_t state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [1:0] ptr, ptr_n, edir, pick_dir;
  logic [3:0] arb_gnt, others, grant_n;
  logic arb_valid, emg, pick_ok, hold, leave;
  logic [3:0][2:0] lights;
  rr_arbiter_4 u_arb (.req(bus.req), .ptr(ptr), .gnt(arb_gnt), .valid(arb_valid));
`ifdef EMERGENCY_PREEMPT_EN
  assign emg = bus.emg_req;
  assign edir = bus.emg_dir;
`else
  assign emg = 1'b0;
  assign edir = DIR_N;
`endif
  // ptr always names the approach currently (or last) served
  assign pick_ok = emg | arb_valid;
  assign pick_dir = emg ? edir : onehot_idx(arb_gnt);
  assign others = bus.req & ~(4'b1 << ptr);
  assign hold = emg && edir == ptr;
  assign leave = (emg && edir != ptr) || (!hold && others != 4'b0 && timer >= CNT_W'(MIN_GREEN - 1));
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    case (state)
      IDLE: begin
        state_n = pick_ok ? GREEN : IDLE;
        ptr_n = pick_ok ? pick_dir : ptr;
      end
      GREEN: state_n = leave ? YELLOW : GREEN;
      YELLOW: state_n = timer == CNT_W'(YELLOW_TIME - 1) ? ALL_RED : YELLOW;
      ALL_RED: if (timer == CNT_W'(ALLRED_TIME - 1)) begin
        state_n = pick_ok ? GREEN : IDLE;
        ptr_n = pick_ok ? pick_dir : ptr;
      end
      default: state_n = IDLE;
    endcase
    timer_n = state_n != state ? '0 :
              (state == IDLE || (state == GREEN && timer == CNT_W'(MAX_GREEN - 1))) ? timer :
              timer + CNT_W'(1);
    grant_n = (state_n == GREEN || state_n == YELLOW) ? 4'b1 << ptr_n : 4'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      ptr <= DIR_W;
      bus.grant <= '0;
      lights <= {4{LIGHT_RED}};
    end else begin
      state <= state_n;
      timer <= timer_n;
      ptr <= ptr_n;
      bus.grant <= grant_n;
      for (int d = 0; d < 4; d++)
        lights[d] <= grant_n[d] ? (state_n == GREEN ? LIGHT_GREEN : LIGHT_YELLOW) : LIGHT_RED;
    end
  end
  assign bus.n_lights = lights[DIR_N];
  assign bus.s_lights = lights[DIR_S];
  assign bus.e_lights = lights[DIR_E];
  assign bus.w_lights = lights[DIR_W];
endmodule
